bus65_responder: RTL

//  Memory/peripheral side of the 65xx bus: answers cpu65 address/RWn cycles with RAM data, inserts wait

---
 rtl/bus65_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bus65_responder.sv
// Memory/peripheral responder for the 65xx bus: mirrored RAM, RAM read wait states,
// a small timer/NMI/halt IO window, and a host preload port.
module bus65_responder #(
    parameter int          AW      = 12,
    parameter logic [15:0] IO_BASE = 16'hFE00,
    parameter int          NMI_LEN = 4
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic [15:0]   A,
    input  logic          RWn,
    input  logic          SYNC,
    input  logic          AEC,
    input  logic [7:0]    D_OUT,
    output logic [7:0]    D_IN,
    output logic          RDY,
    output logic          IRQn,
    output logic          NMIn,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          halted,
    output logic [31:0]   fetch_cnt,
    output logic          wait_state
);

    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [3:0] NMI_LEN4 = 4'(NMI_LEN);

    // Bus handshake: a cycle completes at the rising edge where RDY=1; while RDY=0
    // the CPU holds A/RWn/D_OUT and nothing commits.
    logic [7:0]  ram [2**AW];

    state_t      state;
    logic [2:0]  cnt;
    logic        done;

    logic [15:0] tmr_reload;
    logic [15:0] reload_nxt;
    logic [15:0] tmr_cnt;
    logic        timer_en;
    logic        irq_pend;
    logic [2:0]  wait_n;
    logic [3:0]  nmi_cnt;

    logic        io_sel;
    logic        ram_sel;
    logic [2:0]  io_off;
    logic        stall_req;
    logic        cpu_wr;
    logic        io_wr;
    logic        ram_wr;
    logic        reload_evt;
    logic        expire;
    logic [7:0]  io_rdata;

    assign io_sel     = AEC && (A[15:3] == IO_BASE[15:3]);
    assign ram_sel    = AEC && !io_sel;
    assign io_off     = A[2:0];
    assign stall_req  = (state == IDLE && ram_sel && RWn && wait_n != 3'd0 && !done)
                        || (state == STALL);
    assign RDY        = !stall_req;
    assign cpu_wr     = AEC && !RWn && RDY;
    assign io_wr      = cpu_wr && io_sel;
    assign ram_wr     = cpu_wr && ram_sel;
    assign expire     = timer_en && (tmr_reload != 16'd0) && (tmr_cnt == 16'd0);
    assign reload_evt = io_wr && (io_off == 3'd0 || io_off == 3'd1
                                  || (io_off == 3'd2 && D_OUT[0]));
    assign IRQn       = !irq_pend;
    assign NMIn       = (nmi_cnt == 4'd0);
    assign wait_state = (state == STALL);

    // RAM is deliberately not reset so a host preload survives rst_n.
    always_ff @(posedge clk_i) begin
        if (ram_wr)
            ram[A[AW-1:0]] <= D_OUT;
        else if (ld_en)
            ram[ld_addr] <= ld_data;
    end

    always_comb begin
        io_rdata = 8'hFF;
        case (io_off)
            3'd0: io_rdata = tmr_reload[7:0];
            3'd1: io_rdata = tmr_reload[15:8];
            3'd2: io_rdata = {7'd0, timer_en};
            3'd3: io_rdata = {7'd0, irq_pend};
            3'd4: io_rdata = {5'd0, wait_n};
            3'd5: io_rdata = 8'h00;
            default: io_rdata = 8'hFF;
        endcase
    end

    always_comb begin
        D_IN = 8'hFF;
        if (rst_n && AEC && RWn) begin
            if (ram_sel)
                D_IN = ram[A[AW-1:0]];
            else if (io_sel)
                D_IN = io_rdata;
        end
    end

    always_comb begin
        reload_nxt = tmr_reload;
        if (io_wr && io_off == 3'd0) reload_nxt[7:0]  = D_OUT;
        if (io_wr && io_off == 3'd1) reload_nxt[15:8] = D_OUT;
    end

    // The first stalled cycle is spent in IDLE, so STALL holds for WAIT-1 more cycles.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            done  <= 1'b0;
        end else begin
            if (RDY)
                done <= 1'b0;
            case (state)
                IDLE: begin
                    if (stall_req) begin
                        if (wait_n == 3'd1) begin
                            done <= 1'b1;
                        end else begin
                            state <= STALL;
                            cnt   <= wait_n - 3'd2;
                        end
                    end
                end
                STALL: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tmr_reload <= 16'd0;
            tmr_cnt    <= 16'd0;
            timer_en   <= 1'b0;
            irq_pend   <= 1'b0;
            wait_n     <= 3'd0;
            nmi_cnt    <= 4'd0;
            halted     <= 1'b0;
            fetch_cnt  <= 32'd0;
        end else begin
            tmr_reload <= reload_nxt;
            if (io_wr && io_off == 3'd2)
                timer_en <= D_OUT[0];
            if (io_wr && io_off == 3'd4)
                wait_n <= D_OUT[2:0];
            if (io_wr && io_off == 3'd5)
                halted <= 1'b1;

            if (reload_evt)
                tmr_cnt <= reload_nxt;
            else if (timer_en && tmr_reload != 16'd0)
                tmr_cnt <= (tmr_cnt == 16'd0) ? tmr_reload : tmr_cnt - 16'd1;

            // Expiry beats a simultaneous STATUS clear.
            if (expire)
                irq_pend <= 1'b1;
            else if (io_wr && io_off == 3'd3 && D_OUT[0])
                irq_pend <= 1'b0;

            if (io_wr && io_off == 3'd2 && D_OUT[1])
                nmi_cnt <= NMI_LEN4;
            else if (nmi_cnt != 4'd0)
                nmi_cnt <= nmi_cnt - 4'd1;

            if (SYNC && AEC && RDY)
                fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule
